// File: rtl/mul_div_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_pkg
//
// Shared definitions for the mul_div arithmetic group (multipliers and
// dividers). Holds the common FSM state encoding and a ceiling-log2 helper
// for sizing iteration counters.
//
// Contents:
//   ST_IDLE / ST_CALC / ST_FINISH  2-bit state encoding constants
//   mul_div_state_t                enum built on those constants
//   clog2(value)                   ceil(log2(value)), 0 for value <= 1
// ---------------------------------------------------------------------------
package mul_div_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        CALC   = ST_CALC,
        FINISH = ST_FINISH
    } mul_div_state_t;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mul_sign_mag.sv
// ---------------------------------------------------------------------------
// mul_sign_mag
//
// Combinational sign handling for the shift-add multiplier (and the future
// signed divider). Converts two operands to unsigned magnitudes, produces the
// sign of the result, and conditionally negates a double-width result.
//
// Parameters:
//   WIDTH        operand width in bits
//
// Ports:
//   signed_mode  in   1        1 = operands are two's complement
//   a, b         in   WIDTH    raw operands
//   a_mag, b_mag out  WIDTH    |a|, |b| (unchanged when unsigned)
//   neg          out  1        result sign: signed_mode & (a[MSB] ^ b[MSB])
//   negate       in   1        apply negation to value
//   value        in   2*WIDTH  unsigned result to be signed
//   result       out  2*WIDTH  negate ? -value : value
// ---------------------------------------------------------------------------
module mul_sign_mag #(
    parameter int WIDTH = 8
) (
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic                 neg,
    input  logic                 negate,
    input  logic [2*WIDTH-1:0]   value,
    output logic [2*WIDTH-1:0]   result
);

    logic a_is_neg;
    logic b_is_neg;

    assign a_is_neg = signed_mode & a[WIDTH-1];
    assign b_is_neg = signed_mode & b[WIDTH-1];

    // The most negative value negates to itself in WIDTH bits, which read as
    // unsigned is exactly its magnitude, so no extra bit is needed.
    always_comb begin
        a_mag = a_is_neg ? (~a + 1'b1) : a;
        b_mag = b_is_neg ? (~b + 1'b1) : b;
        neg   = a_is_neg ^ b_is_neg;
    end

    // Negating zero yields zero, so a zero product never comes out as -0.
    always_comb begin
        result = negate ? (~value + 1'b1) : value;
    end

endmodule

// File: rtl/shift_add_multiplier_param.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_param
//
// Multi-cycle radix-2 shift-add multiplier with per-operation signed or
// unsigned mode. One multiplier bit is consumed per CALC cycle; a FINISH
// cycle then registers the signed product and pulses done.
//
// Parameters:
//   WIDTH        operand width, 2..32; product is 2*WIDTH bits
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        request; accepted only in IDLE or FINISH
//   signed_mode  in   1        1 = two's complement operands
//   a            in   WIDTH    multiplicand
//   b            in   WIDTH    multiplier
//   p            out  2*WIDTH  product, held until the next FINISH
//   busy         out  1        operation in progress
//   done         out  1        one-cycle pulse when p is updated
//
// Build option:
//   SHIFT_ADD_EARLY_TERM_EN  when defined, CALC ends as soon as the remaining
//                            multiplier bits are all zero.
// ---------------------------------------------------------------------------
module shift_add_multiplier_param
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);

    localparam int               CW   = clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    mul_div_state_t        state;
    logic [WIDTH-1:0]      mcand;
    logic [WIDTH-1:0]      mplier;
    logic [2*WIDTH-1:0]    acc;
    logic [CW-1:0]         count;
    logic                  neg;

    logic [WIDTH-1:0]      a_mag;
    logic [WIDTH-1:0]      b_mag;
    logic                  op_neg;
    logic [2*WIDTH-1:0]    product;

    logic [2*WIDTH-1:0]    addend;
    logic [2*WIDTH-1:0]    acc_sum;
    logic [WIDTH-1:0]      mplier_shr;
    logic                  calc_last;

    mul_sign_mag #(
        .WIDTH       (WIDTH)
    ) u_sign_mag (
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .a_mag       (a_mag),
        .b_mag       (b_mag),
        .neg         (op_neg),
        .negate      (neg),
        .value       (acc),
        .result      (product)
    );

    // Partial product for the current multiplier bit, aligned by count.
    always_comb begin
        addend     = {{WIDTH{1'b0}}, mcand} << count;
        acc_sum    = acc + (mplier[0] ? addend : '0);
        mplier_shr = mplier >> 1;
    end

    // Last CALC cycle: all WIDTH bits consumed, or (with early termination)
    // no set bits remain in the shifted multiplier.
`ifdef SHIFT_ADD_EARLY_TERM_EN
    always_comb begin
        calc_last = (count == LAST) || (mplier_shr == '0);
    end
`else
    always_comb begin
        calc_last = (count == LAST);
    end
`endif

    // Control FSM and datapath registers. When a new operation is accepted
    // in the FINISH cycle, done pulses in the first CALC cycle, so busy is
    // held low for that one cycle and rises on the next; done and busy are
    // therefore never high together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            p      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (state == FINISH) begin
                        p    <= product;
                        done <= 1'b1;
                    end
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= op_neg;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= (state == IDLE);
                        state  <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mplier <= mplier_shr;
                    count  <= count + CW'(1);
                    busy   <= !calc_last;
                    if (calc_last) begin
                        state <= FINISH;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier_param.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier_param
//
// Self-checking bench for shift_add_multiplier_param. Two instances are
// exercised (WIDTH=4 and WIDTH=8) against a reference model that computes
// products with plain integer arithmetic and latency from the operand
// magnitude. Follows SHIFT_ADD_EARLY_TERM_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier_param;

`ifdef SHIFT_ADD_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start4, sm4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        busy4, done4;

    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        busy8, done8;

    bit          sel8;
    logic        curDone, curBusy;
    logic [15:0] curP;

    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        int          w;
        bit          sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t dirVec[10];

    shift_add_multiplier_param #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start4),
        .signed_mode (sm4),
        .a           (a4),
        .b           (b4),
        .p           (p4),
        .busy        (busy4),
        .done        (done4)
    );

    shift_add_multiplier_param #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .p           (p8),
        .busy        (busy8),
        .done        (done8)
    );

    always #5 clk = ~clk;

    always_comb begin
        curDone = sel8 ? done8 : done4;
        curBusy = sel8 ? busy8 : busy4;
        curP    = sel8 ? p8 : {8'h00, p4};
    end

    // Reference product: interpret operands per mode, multiply, keep 2*w bits.
    function automatic logic [63:0] refProduct(input int w, input bit sm,
                                               input logic [31:0] a, input logic [31:0] b);
        longint m, av, bv, prod;
        m  = (longint'(1) << w) - 1;
        av = longint'(a) & m;
        bv = longint'(b) & m;
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        prod = av * bv;
        return 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Reference latency from accepting edge to done: fixed w+1, or
    // max(1, bitlen(|b|)) + 1 with early termination.
    function automatic int refLatency(input int w, input bit sm, input logic [31:0] b);
        longint mag;
        int     bl;
        mag = longint'(b) & ((longint'(1) << w) - 1);
        if (sm && b[w-1]) mag = (longint'(1) << w) - mag;
        bl = 0;
        while (mag > 0) begin
            bl  = bl + 1;
            mag = mag >> 1;
        end
        if (bl < 1) bl = 1;
        return EARLY_TERM ? (bl + 1) : (w + 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveInputs(input int w, input bit st, input bit sm,
                               input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            start8 = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start4 = st; sm4 = sm; a4 = a[3:0]; b4 = b[3:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One operation issued from IDLE: checks latency, product, busy length,
    // busy/done exclusivity, single-cycle done and held product.
    task automatic applyStimulus(input string tag, input int w, input bit sm,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expP);
        int expLat, lat, busyCycles, overlap;
        sel8 = (w == 8);
        expLat = refLatency(w, sm, b);
        @(negedge clk);
        driveInputs(w, 1'b1, sm, a, b);
        tick();
        driveInputs(w, 1'b0, 1'b0, ~a, ~b);
        lat = 0; busyCycles = 0; overlap = 0;
        for (int cyc = 1; cyc <= 64 && lat == 0; cyc++) begin
            if (curBusy) busyCycles++;
            if (curBusy && curDone) overlap++;
            tick();
            if (curDone) lat = cyc;
        end
        checkOutput($sformatf("%s latency", tag), 64'(lat), 64'(expLat));
        checkOutput($sformatf("%s p", tag), 64'(curP), expP);
        checkOutput($sformatf("%s busy_cycles", tag), 64'(busyCycles), 64'(expLat - 1));
        checkOutput($sformatf("%s busy_at_done", tag), 64'(curBusy | overlap[0]), 64'd0);
        tick();
        checkOutput($sformatf("%s done_pulse", tag), 64'(curDone), 64'd0);
        checkOutput($sformatf("%s p_hold", tag), 64'(curP), expP);
    endtask

    initial begin
        int lat1, lat2, dones;
        logic [31:0] ra, rb;
        bit rsm;

        rst_n = 1'b0;
        sel8  = 1'b0;
        driveInputs(4, 1'b0, 1'b0, 32'h0, 32'h0);
        driveInputs(8, 1'b0, 1'b0, 32'h0, 32'h0);

        dirVec[0] = '{4, 1'b0, 32'h6,  32'h3,  64'd18};
        dirVec[1] = '{4, 1'b1, 32'hD,  32'h5,  64'hF1};
        dirVec[2] = '{4, 1'b1, 32'h8,  32'h8,  64'h40};
        dirVec[3] = '{4, 1'b0, 32'hF,  32'hF,  64'd225};
        dirVec[4] = '{4, 1'b0, 32'h0,  32'h9,  64'd0};
        dirVec[5] = '{8, 1'b1, 32'h80, 32'h01, 64'hFF80};
        dirVec[6] = '{8, 1'b0, 32'h5,  32'h0,  64'd0};
        dirVec[7] = '{8, 1'b0, 32'h7,  32'h3,  64'd21};
        dirVec[8] = '{8, 1'b0, 32'h5A, 32'hFF, 64'd22950};
        dirVec[9] = '{8, 1'b0, 32'd200, 32'd100, 64'd20000};

        repeat (3) @(negedge clk);
        checkOutput("reset p4", 64'(p4), 64'd0);
        checkOutput("reset busy4", 64'(busy4), 64'd0);
        checkOutput("reset done4", 64'(done4), 64'd0);
        checkOutput("reset p8", 64'(p8), 64'd0);
        checkOutput("reset busy8", 64'(busy8), 64'd0);
        checkOutput("reset done8", 64'(done8), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("dir%0d", i), dirVec[i].w, dirVec[i].sm,
                          dirVec[i].a, dirVec[i].b, dirVec[i].p);
        end

        for (int i = 0; i < 60; i++) begin
            int w;
            w   = (i % 2 == 0) ? 4 : 8;
            ra  = $urandom;
            rb  = $urandom;
            rsm = 1'($urandom_range(0, 1));
            if (i % 10 == 3) rb = 32'h0;
            applyStimulus($sformatf("rnd%0d_w%0d", i, w), w, rsm, ra, rb,
                          refProduct(w, rsm, ra, rb));
        end

        // Back-to-back: second start presented during the FINISH cycle.
        sel8 = 1'b1;
        lat1 = refLatency(8, 1'b0, 32'h2B);
        @(negedge clk);
        driveInputs(8, 1'b1, 1'b0, 32'h13, 32'h2B);
        tick();
        driveInputs(8, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (lat1 - 1) tick();
        checkOutput("b2b done_before", 64'(curDone), 64'd0);
        driveInputs(8, 1'b1, 1'b0, 32'd200, 32'd100);
        tick();
        driveInputs(8, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("b2b first_done", 64'(curDone), 64'd1);
        checkOutput("b2b first_p", 64'(curP), refProduct(8, 1'b0, 32'h13, 32'h2B));
        checkOutput("b2b busy_at_done", 64'(curBusy), 64'd0);
        lat2 = 0;
        for (int cyc = 1; cyc <= 64 && lat2 == 0; cyc++) begin
            tick();
            if (curDone) lat2 = cyc;
        end
        checkOutput("b2b spacing", 64'(lat2), 64'(refLatency(8, 1'b0, 32'd100)));
        checkOutput("b2b second_p", 64'(curP), 64'd20000);
        tick();

        // start pulsed mid-CALC must be ignored and not queued.
        @(negedge clk);
        driveInputs(8, 1'b1, 1'b0, 32'h35, 32'hC3);
        tick();
        driveInputs(8, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        driveInputs(8, 1'b1, 1'b1, 32'hFF, 32'hFF);
        tick();
        driveInputs(8, 1'b0, 1'b0, 32'h0, 32'h0);
        lat1 = 0;
        for (int cyc = 3; cyc <= 64 && lat1 == 0; cyc++) begin
            tick();
            if (curDone) lat1 = cyc;
        end
        checkOutput("ignore latency", 64'(lat1), 64'(refLatency(8, 1'b0, 32'hC3)));
        checkOutput("ignore p", 64'(curP), 64'(16'h35 * 16'hC3));
        dones = 0;
        repeat (15) begin
            tick();
            if (curDone) dones++;
        end
        checkOutput("ignore no_queue", 64'(dones), 64'd0);

        // Reset two cycles into CALC abandons the operation.
        @(negedge clk);
        driveInputs(8, 1'b1, 1'b0, 32'h9A, 32'hB7);
        tick();
        driveInputs(8, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst p", 64'(p8), 64'd0);
        checkOutput("midrst busy", 64'(busy8), 64'd0);
        checkOutput("midrst done", 64'(done8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            tick();
            if (curDone) dones++;
        end
        checkOutput("midrst no_done", 64'(dones), 64'd0);
        checkOutput("midrst p_after", 64'(p8), 64'd0);
        applyStimulus("postrst", 8, 1'b1, 32'h9A, 32'hB7,
                      refProduct(8, 1'b1, 32'h9A, 32'hB7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/shift_add_multiplier_param.md
Name: shift_add_multiplier_param

Overview:
- Parametrised, multi-cycle, radix-2 shift-add multiplier.
- Adds WIDTH generalisation, signed/unsigned mode per operation, a busy indicator, ignoring of start while busy, and back-to-back issue.
- Sits in the mul_div arithmetic group; used by datapaths that trade latency for area instead of using a combinational array multiplier.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when the block is idle or in FINISH.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with start.
- a  input  WIDTH  multiplicand, sampled with an accepted start.
- b  input  WIDTH  multiplier, sampled with an accepted start.
- p  output  2*WIDTH  registered product; holds its value until the next FINISH.
- busy  output  1  high from the cycle after an accepted start until FINISH.
- done  output  1  one-cycle pulse when p is valid.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - p=0, busy=0, done=0; internal accumulator, count and sign registers are cleared.
  - Reset mid-operation abandons the operation; p does not update.
- States: IDLE, CALC, FINISH.
- Accept: start=1 at an edge with state IDLE or FINISH.
  - Latch |a| and |b| as unsigned WIDTH-bit magnitudes (abs only if signed_mode=1 and the MSB is set).
  - Latch neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator and count; go to CALC.
- start while in CALC is ignored, with no queueing and no effect on the running operation.
- CALC (one multiplier bit per cycle):
  - If mplier[0]=1, acc += mcand << count.
  - mplier >>= 1; count++.
  - After WIDTH cycles, go to FINISH.
- FINISH (one cycle):
  - p <= neg ? -acc : acc, truncated to 2*WIDTH.
  - done=1, busy=0.
  - Next state is CALC if start is accepted, else IDLE.
- Latency: start sampled at edge k; done and the new p are visible after edge k+WIDTH+1. Throughput is one result per WIDTH+1 cycles with back-to-back start.
- Width rule: the magnitude of the most negative value (-2^(WIDTH-1)) fits in WIDTH unsigned bits, so there is no overflow. (-2^(W-1))^2 = 2^(2W-2) fits in 2*WIDTH signed.
- Zero operand: runs full latency (unless the optional feature is enabled); p=0 with no negative zero, because neg applied to 0 yields 0.
- busy and done are never high together.

Optional Feature:
- Macro: SHIFT_ADD_EARLY_TERM_EN.
- Defined:
  - CALC exits to FINISH after the cycle in which the shifted mplier becomes 0, or after count reaches WIDTH.
  - Latency = max(1, bitlen(|b|)) + 1 cycles. Example: b=0 gives done at k+2; b=3 gives done at k+3.
  - Results are identical to the undefined case.
- Undefined: fixed latency WIDTH+1; no zero-detect logic is generated.

Decomposition:
- Shared package mul_div_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_FINISH=2'd2.
  - Counter width function clog2.
  - These constants are shared with the divider blocks.
- One sub-module, mul_sign_mag: combinational magnitude extraction (abs) and conditional negate. It is reused by the future signed divider. Everything else stays in this module.

Test Plan:
- WIDTH=4, unsigned, a=6, b=3, start at edge k: done pulses after edge k+5; p=8'd18; busy high for 4 cycles.
- WIDTH=4, signed, a=4'hD (-3), b=4'h5 (+5): p=8'hF1 (-15). Also run a=4'h8, b=4'h8 (-8*-8): p=8'h40.
- WIDTH=4, unsigned corner cases:
  - a=15, b=15: p=8'd225.
  - a=0, b=9: p=0 with done at k+5.
  - WIDTH=8, signed, a=8'h80, b=8'h01: p=16'hFF80.
- Back-to-back, WIDTH=8:
  - start held high in the FINISH cycle with a=200, b=100, unsigned: second done exactly 9 cycles after the first; p=16'd20000.
  - start pulsed mid-CALC with different operands: ignored; first result unchanged.
- Reset mid-operation: rst_n=0 two cycles into CALC. p, busy and done are 0 immediately (async). After release with no start there is no done pulse; a new start gives the correct product.
- SHIFT_ADD_EARLY_TERM_EN defined, WIDTH=8:
  - b=0: done at k+2, p=0.
  - b=3, a=7: done at k+3, p=21.
  - b=8'hFF, unsigned: done at k+9.
